// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by fetch and data.
// Data wins ties; a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;

  logic if_elig, d_elig, at_limit;
  logic grant_if, grant_d;

  // A requester in its done cycle is still releasing; never re-grant it.
  assign if_elig  = if_req & ~if_done_q;
  assign d_elig   = d_req & ~d_done_q;
  assign at_limit = (starve_q == LIMIT);
  assign grant_if = (state_q == IDLE) & if_elig
                  & (~d_elig | at_limit);
  assign grant_d  = (state_q == IDLE) & d_elig & ~grant_if;

  // Next-state, grant capture and completion handling.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = 4'd0;
        end else if (grant_d) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req)
            starve_d = 4'd0;
          else if (!at_limit)
            starve_d = starve_q + 4'd1;
        end
      end
      FETCH, DATA: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == FETCH) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q)
              d_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign if_stall  = if_req & ~if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign d_stall   = d_req & ~d_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random fetch/data traffic against a
// rule-level reference model with a queue-based scoreboard.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done, if_stall;
  logic          d_req, d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_done, d_stall;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack, busy;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;
  typedef struct {
    int cyc;
    int who;
  } dn_t;

  gnt_t gq[$];
  dn_t  dq[$];
  gnt_t cur;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: who owns the port (0 none, 1 IF, 2 D).
  int            m_own = 0;
  bit            m_we = 0;
  bit            m_ifd = 0, m_dd = 0;
  logic [DW-1:0] m_ifrd = '0, m_drd = '0;
  int            starve = 0;

  bit if_act = 0, d_act = 0;
  bit if_gnt = 0, d_gnt = 0;
  bit pend = 0;
  int left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               nm, cyc, act, exp);
  endtask

  // Monitor: compare registered outputs with the scoreboard.
  always @(negedge clk) begin
    bit   bz, e_if, e_d;
    dn_t  e;
    bz = (m_own != 0);
    chk("mem_req", mem_req, bz);
    chk("busy", busy, bz);
    if (gq.size() > 0 && gq[0].cyc == cyc)
      cur = gq.pop_front();
    if (bz) begin
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_we", mem_we, cur.we);
      chk("mem_be", mem_be, cur.be);
      if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
    end
    e_if = 0;
    e_d  = 0;
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      e = dq.pop_front();
      if (e.who == 1) e_if = 1;
      else e_d = 1;
    end
    chk("if_done", if_done, e_if);
    chk("d_done", d_done, e_d);
    chk("if_rdata", if_rdata, m_ifrd);
    chk("d_rdata", d_rdata, m_drd);
  end

  task automatic clr_inputs();
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = '0;
    d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic model_reset();
    m_own = 0; m_we = 0; m_ifd = 0; m_dd = 0;
    m_ifrd = '0; m_drd = '0; starve = 0;
    if_act = 0; d_act = 0; if_gnt = 0; d_gnt = 0;
    pend = 0; left = 0;
    gq.delete();
    dq.delete();
  endtask

  // Requesters: hold until done, scramble fields once granted.
  task automatic drive_reqs(int p);
    if (m_ifd) begin if_act = 0; if_gnt = 0; end
    if (m_dd) begin d_act = 0; d_gnt = 0; end
    if (!if_act) begin
      if ($urandom_range(99) < p) begin
        if_req = 1; if_addr = $urandom; if_act = 1;
      end else if_req = 0;
    end else if (if_gnt) begin
      if_addr = $urandom;
      if ($urandom_range(15) == 0) if_req = 0;
    end
    if (!d_act) begin
      if ($urandom_range(99) < p) begin
        d_req = 1; d_we = $urandom_range(1);
        d_be = 4'($urandom_range(1, 15));
        d_addr = $urandom; d_wdata = $urandom;
        d_act = 1;
      end else d_req = 0;
    end else if (d_gnt) begin
      d_we = ~d_we; d_be = 4'($urandom);
      d_addr = $urandom; d_wdata = $urandom;
      if ($urandom_range(15) == 0) d_req = 0;
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(9);
    if (r == 0) return 10;
    if (r < 5) return 1;
    return $urandom_range(2, 4);
  endfunction

  // Memory: ack 1..10 cycles after mem_req rises, stray acks idle.
  task automatic drive_mem();
    mem_ack = 0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!pend) begin pend = 1; left = pick_lat(); end
      else left--;
      if (left == 0) begin mem_ack = 1; pend = 0; end
    end else begin
      pend = 0;
      if ($urandom_range(15) == 0) mem_ack = 1;
    end
  endtask

  // Advance the model one cycle from this cycle's inputs.
  task automatic model_step();
    bit nifd, ndd, ife, de;
    nifd = 0;
    ndd = 0;
    if (m_own != 0) begin
      if (mem_ack) begin
        if (m_own == 1) begin
          nifd = 1; m_ifrd = mem_rdata;
        end else begin
          ndd = 1;
          if (!m_we) m_drd = mem_rdata;
        end
        dq.push_back('{cyc + 1, m_own});
        m_own = 0;
      end
    end else begin
      ife = if_req && !m_ifd;
      de  = d_req && !m_dd;
      if (ife && (!de || starve == LIM)) begin
        m_own = 1; m_we = 0; if_gnt = 1; starve = 0;
        gq.push_back('{cyc + 1, 1'b0, 4'hF,
                       if_addr, 32'h0});
      end else if (de) begin
        m_own = 2; m_we = d_we; d_gnt = 1;
        if (!if_req) starve = 0;
        else if (starve < LIM) starve++;
        gq.push_back('{cyc + 1, d_we, d_be,
                       d_addr, d_wdata});
      end
    end
    m_ifd = nifd;
    m_dd  = ndd;
  endtask

  task automatic step(int p);
    @(negedge clk);
    drive_reqs(p);
    drive_mem();
    #1;
    chk("if_stall", if_stall, if_req & ~m_ifd);
    chk("d_stall", d_stall, d_req & ~m_dd);
    model_step();
  endtask

  task automatic run(int n, int p);
    for (int i = 0; i < n; i++) step(p);
  endtask

  // Abort a data access with an asynchronous reset.
  task automatic reset_mid();
    int n;
    n = 0;
    while (!(m_own == 2 && mem_req === 1'b1) && n < 2000) begin
      step(60);
      n++;
    end
    @(negedge clk);
    mem_ack = 0;
    #2;
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_d_done", d_done, 1'b0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    model_reset();
    clr_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clr_inputs();
    @(negedge clk);
    chk("r_mem_req", mem_req, 1'b0);
    chk("r_mem_we", mem_we, 1'b0);
    chk("r_mem_be", mem_be, 4'h0);
    chk("r_mem_addr", mem_addr, 32'h0);
    chk("r_mem_wdata", mem_wdata, 32'h0);
    chk("r_if_rdata", if_rdata, 32'h0);
    chk("r_d_rdata", d_rdata, 32'h0);
    chk("r_if_done", if_done, 1'b0);
    chk("r_d_done", d_done, 1'b0);
    chk("r_busy", busy, 1'b0);
    chk("r_if_stall", if_stall, 1'b0);
    chk("r_d_stall", d_stall, 1'b0);
    @(negedge clk);
    reset = 0;
    run(1000, 30);
    run(1000, 100);
    reset_mid();
    run(1000, 50);
    run(500, 10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
